// File: rtl/divmon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : divmon_pkg
//  Description : Shared types and constants for the divided-clock monitor.
//                Holds the monitor FSM state encoding and the reset value
//                used for the reported phase lengths.
//  Revision    : 1.0  initial release
// ============================================================================
package divmon_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } divmon_state_t;

    // Value loaded into the reported high/low lengths on reset.
    localparam logic [31:0] DIVMON_RST_LEN = '0;

endpackage : divmon_pkg
`default_nettype wire

// File: rtl/divmon_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : divmon_edge_det
//  Description : Registers the previous sample of the divided clock and flags
//                rising/falling edges of the current sample against it.
//  Ports       : clk    in  system clock, posedge
//                rst    in  synchronous reset, active-high (prev cleared to 0)
//                i_d    in  sampled divided clock
//                o_rise out i_d & ~prev
//                o_fall out ~i_d & prev
//  Revision    : 1.0  initial release
// ============================================================================
module divmon_edge_det
    import divmon_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_d;
        end
    end

    assign o_rise = i_d & ~r_prev;
    assign o_fall = ~i_d & r_prev;

endmodule : divmon_edge_det
`default_nettype wire

// File: rtl/div_clk_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : div_clk_monitor
//  Description : Checks the output of a fixed-ratio clock divider. Measures
//                the high and low phase length of every full period in clk
//                samples, compares them with the expected values, and reports
//                per-period lengths, a lock flag and error pulses.
//  Ports       : clk          in   system clock, posedge
//                rst          in   synchronous reset, active-high
//                i_en         in   monitor enable
//                i_div_in     in   divided clock under test
//                o_high_len   out  high samples of last completed period
//                o_low_len    out  low samples of last completed period
//                o_meas_valid out  1-cycle pulse, lengths updated
//                o_locked     out  LOCK_PERIODS consecutive good periods seen
//                o_err        out  1-cycle pulse, mismatch or timeout
//                o_err_cnt    out  saturating error count
//  Config      : DIVMON_ERRCNT_EN defined  -> o_err_cnt counts err pulses
//                DIVMON_ERRCNT_EN undefined -> o_err_cnt tied to zero
//  Revision    : 1.0  initial release
// ============================================================================
module div_clk_monitor
    import divmon_pkg::*;
#(
    parameter int EXP_HIGH     = 4,
    parameter int EXP_LOW      = 3,
    parameter int CNT_W        = 8,
    parameter int LOCK_PERIODS = 2,
    parameter int ERR_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_div_in,
    output logic [CNT_W-1:0]     o_high_len,
    output logic [CNT_W-1:0]     o_low_len,
    output logic                 o_meas_valid,
    output logic                 o_locked,
    output logic                 o_err,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    localparam int               MATCH_W    = $clog2(LOCK_PERIODS + 1);
    // A counter about to reach all-ones means the input is stuck.
    localparam logic [CNT_W-1:0] c_cnt_lim  = CNT_W'((2 ** CNT_W) - 2);
    localparam logic [CNT_W-1:0] c_exp_high = CNT_W'(EXP_HIGH);
    localparam logic [CNT_W-1:0] c_exp_low  = CNT_W'(EXP_LOW);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
    localparam logic [MATCH_W-1:0] c_lock_n = MATCH_W'(LOCK_PERIODS);

    logic w_rise;
    logic w_fall;

    divmon_edge_det u_edge (
        .clk    (clk),
        .rst    (rst),
        .i_d    (i_div_in),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    divmon_state_t      r_state,      w_state_nxt;
    logic [CNT_W-1:0]   r_hcnt,       w_hcnt_nxt;
    logic [CNT_W-1:0]   r_lcnt,       w_lcnt_nxt;
    logic [MATCH_W-1:0] r_match_cnt,  w_match_nxt;
    logic [CNT_W-1:0]   r_high_len,   w_high_len_nxt;
    logic [CNT_W-1:0]   r_low_len,    w_low_len_nxt;
    logic               r_meas_valid, w_meas_valid_nxt;
    logic               r_locked,     w_locked_nxt;
    logic               r_err,        w_err_nxt;
    logic               w_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_hcnt       <= '0;
            r_lcnt       <= '0;
            r_match_cnt  <= '0;
            r_high_len   <= CNT_W'(DIVMON_RST_LEN);
            r_low_len    <= CNT_W'(DIVMON_RST_LEN);
            r_meas_valid <= 1'b0;
            r_locked     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hcnt       <= w_hcnt_nxt;
            r_lcnt       <= w_lcnt_nxt;
            r_match_cnt  <= w_match_nxt;
            r_high_len   <= w_high_len_nxt;
            r_low_len    <= w_low_len_nxt;
            r_meas_valid <= w_meas_valid_nxt;
            r_locked     <= w_locked_nxt;
            r_err        <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_hcnt_nxt       = r_hcnt;
        w_lcnt_nxt       = r_lcnt;
        w_match_nxt      = r_match_cnt;
        w_high_len_nxt   = r_high_len;
        w_low_len_nxt    = r_low_len;
        w_meas_valid_nxt = 1'b0;
        w_locked_nxt     = r_locked;
        w_err_nxt        = 1'b0;
        w_timeout        = 1'b0;

        if (!i_en) begin
            // Disabling is not an error: drop lock quietly, keep the lengths.
            w_state_nxt  = IDLE;
            w_locked_nxt = 1'b0;
            w_match_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = WAIT_RISE;
                end
                WAIT_RISE: begin
                    // Whatever partial period preceded this rise is discarded.
                    if (w_rise) begin
                        w_state_nxt = MEAS_HIGH;
                        w_hcnt_nxt  = c_one;
                    end
                end
                MEAS_HIGH: begin
                    // Only entered on a rise, so a low sample here is a fall.
                    if (w_fall) begin
                        w_state_nxt = MEAS_LOW;
                        w_lcnt_nxt  = c_one;
                    end else if (r_hcnt == c_cnt_lim) begin
                        w_timeout = 1'b1;
                    end else begin
                        w_hcnt_nxt = r_hcnt + c_one;
                    end
                end
                MEAS_LOW: begin
                    if (w_rise) begin
                        // Closing rise: report this period, start the next.
                        w_state_nxt      = MEAS_HIGH;
                        w_hcnt_nxt       = c_one;
                        w_high_len_nxt   = r_hcnt;
                        w_low_len_nxt    = r_lcnt;
                        w_meas_valid_nxt = 1'b1;
                        if ((r_hcnt == c_exp_high) && (r_lcnt == c_exp_low)) begin
                            if (r_match_cnt != c_lock_n) begin
                                w_match_nxt = r_match_cnt + 1'b1;
                            end
                            w_locked_nxt = (w_match_nxt == c_lock_n);
                        end else begin
                            w_err_nxt    = 1'b1;
                            w_locked_nxt = 1'b0;
                            w_match_nxt  = '0;
                        end
                    end else if (r_lcnt == c_cnt_lim) begin
                        w_timeout = 1'b1;
                    end else begin
                        w_lcnt_nxt = r_lcnt + c_one;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase

            if (w_timeout) begin
                w_state_nxt  = WAIT_RISE;
                w_err_nxt    = 1'b1;
                w_locked_nxt = 1'b0;
                w_match_nxt  = '0;
            end
        end
    end

`ifdef DIVMON_ERRCNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // Counts alongside the err pulse so both become visible together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_err_nxt && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign o_err_cnt = r_err_cnt;
`else
    assign o_err_cnt = '0;
`endif

    assign o_high_len   = r_high_len;
    assign o_low_len    = r_low_len;
    assign o_meas_valid = r_meas_valid;
    assign o_locked     = r_locked;
    assign o_err        = r_err;

endmodule : div_clk_monitor
`default_nettype wire

// File: tb/tb_div_clk_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_clk_monitor
//  Description : Self-checking bench for div_clk_monitor. Directed scenarios
//                followed by randomized divider periods, enable drops and
//                resets, all compared every cycle against a run-length
//                reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_clk_monitor;

    logic       clk;
    logic       rst;
    logic       i_en;
    logic       i_div_in;
    logic [7:0] o_high_len;
    logic [7:0] o_low_len;
    logic       o_meas_valid;
    logic       o_locked;
    logic       o_err;
    logic [7:0] o_err_cnt;

    int n_chk = 0;
    int n_err = 0;

    div_clk_monitor #(
        .EXP_HIGH     (4),
        .EXP_LOW      (3),
        .CNT_W        (8),
        .LOCK_PERIODS (2),
        .ERR_CNT_W    (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_en         (i_en),
        .i_div_in     (i_div_in),
        .o_high_len   (o_high_len),
        .o_low_len    (o_low_len),
        .o_meas_valid (o_meas_valid),
        .o_locked     (o_locked),
        .o_err        (o_err),
        .o_err_cnt    (o_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (run lengths of the input) ----------
    bit m_idle;      // first enabled sample after reset/disable is ignored
    bit m_meas;      // a rise has been seen, a period is being measured
    int m_hi, m_lo;  // samples of the current high and low run
    int m_match;     // consecutive good periods, capped at 2
    bit m_prev;
    int e_hl, e_ll, e_ecnt;
    bit e_mv, e_err, e_lock;

    // Observed pulse tallies used by directed scenarios.
    int obs_err_pulses, obs_mv_pulses;

    task automatic model_step(input bit d, input bit e, input bit r);
        bit rise;
        bit to;
        e_mv  = 1'b0;
        e_err = 1'b0;
        to    = 1'b0;
        if (r) begin
            m_idle = 1'b1; m_meas = 1'b0; m_hi = 0; m_lo = 0; m_match = 0;
            m_prev = 1'b0; e_hl = 0; e_ll = 0; e_lock = 1'b0; e_ecnt = 0;
            return;
        end
        rise = d && !m_prev;
        if (!e) begin
            m_idle = 1'b1; m_meas = 1'b0; e_lock = 1'b0; m_match = 0;
        end else if (m_idle) begin
            m_idle = 1'b0;
        end else if (!m_meas) begin
            if (rise) begin m_meas = 1'b1; m_hi = 1; m_lo = 0; end
        end else if (m_lo == 0) begin
            if (d) begin
                m_hi++;
                if (m_hi >= 255) to = 1'b1;
            end else begin
                m_lo = 1;
            end
        end else if (rise) begin
            e_mv = 1'b1; e_hl = m_hi; e_ll = m_lo;
            if (m_hi == 4 && m_lo == 3) begin
                m_match = (m_match >= 2) ? 2 : m_match + 1;
                e_lock  = (m_match == 2);
            end else begin
                e_err = 1'b1; e_lock = 1'b0; m_match = 0;
            end
            m_hi = 1; m_lo = 0;
        end else begin
            m_lo++;
            if (m_lo >= 255) to = 1'b1;
        end
        if (to) begin
            e_err = 1'b1; e_lock = 1'b0; m_match = 0; m_meas = 1'b0;
        end
`ifdef DIVMON_ERRCNT_EN
        if (e_err && e_ecnt < 255) e_ecnt++;
`endif
        m_prev = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs at negedge, update model at posedge, compare 1ns later.
    task automatic drive(input bit d, input bit e, input bit r);
        @(negedge clk);
        i_div_in = d;
        i_en     = e;
        rst      = r;
        @(posedge clk);
        model_step(d, e, r);
        #1;
        chk("high_len",   32'(o_high_len), 32'(e_hl));
        chk("low_len",    32'(o_low_len),  32'(e_ll));
        chk("meas_valid", 32'(o_meas_valid), 32'(e_mv));
        chk("locked",     32'(o_locked),   32'(e_lock));
        chk("err",        32'(o_err),      32'(e_err));
        chk("err_cnt",    32'(o_err_cnt),  32'(e_ecnt));
        if (o_err === 1'b1) obs_err_pulses++;
        if (o_meas_valid === 1'b1) obs_mv_pulses++;
    endtask

    task automatic period(input int h, input int l, input bit e);
        for (int i = 0; i < h; i++) drive(1'b1, e, 1'b0);
        for (int i = 0; i < l; i++) drive(1'b0, e, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sel;
        int exp_ecnt;
        rst = 1'b1; i_en = 1'b0; i_div_in = 1'b0;

        // Reset state
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        chk("rst_locked", 32'(o_locked), 32'd0);
        chk("rst_hl",     32'(o_high_len), 32'd0);

        // 1. ideal div7 stream, starting mid-high (partial period)
        obs_err_pulses = 0; obs_mv_pulses = 0;
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        period(0, 3, 1'b1);
        for (int p = 0; p < 5; p++) period(4, 3, 1'b1);
        chk("t1_locked",   32'(o_locked), 32'd1);
        chk("t1_hl",       32'(o_high_len), 32'd4);
        chk("t1_ll",       32'(o_low_len), 32'd3);
        chk("t1_mv_count", 32'(obs_mv_pulses), 32'd4);
        chk("t1_no_err",   32'(obs_err_pulses), 32'd0);

        // 2. one 5/3 period while locked
        period(5, 3, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        chk("t2_err",    32'(o_err), 32'd1);
        chk("t2_hl",     32'(o_high_len), 32'd5);
        chk("t2_locked", 32'(o_locked), 32'd0);
`ifdef DIVMON_ERRCNT_EN
        exp_ecnt = 1;
`else
        exp_ecnt = 0;
`endif
        chk("t2_err_cnt", 32'(o_err_cnt), 32'(exp_ecnt));
        period(3, 3, 1'b1);
        period(4, 3, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        chk("t2_relock", 32'(o_locked), 32'd1);
        period(3, 3, 1'b1);

        // 3. stuck high for 300 samples
        drive(1'b1, 1'b1, 1'b0);
        obs_err_pulses = 0; obs_mv_pulses = 0;
        for (int i = 0; i < 299; i++) drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 1'b0);
        chk("t3_err_pulses", 32'(obs_err_pulses), 32'd1);
        chk("t3_no_mv",      32'(obs_mv_pulses), 32'd0);
        chk("t3_locked",     32'(o_locked), 32'd0);

        // 4. drop enable in the low phase while locked
        for (int p = 0; p < 3; p++) period(4, 3, 1'b1);
        period(4, 2, 1'b1);
        chk("t4_locked_before", 32'(o_locked), 32'd1);
        obs_err_pulses = 0;
        drive(1'b0, 1'b0, 1'b0);
        chk("t4_locked_drop", 32'(o_locked), 32'd0);
        drive(1'b0, 1'b0, 1'b0);
        for (int p = 0; p < 4; p++) period(4, 3, 1'b1);
        chk("t4_no_err", 32'(obs_err_pulses), 32'd0);
        chk("t4_relock", 32'(o_locked), 32'd1);

        // 5. reset during the high phase
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        chk("t5_hl",      32'(o_high_len), 32'd0);
        chk("t5_locked",  32'(o_locked), 32'd0);
        chk("t5_err_cnt", 32'(o_err_cnt), 32'd0);
        period(1, 3, 1'b1);

        // Randomized periods, disables and resets
        for (int it = 0; it < 250; it++) begin
            sel = $urandom_range(0, 11);
            if (sel <= 5) begin
                period(4, 3, 1'b1);
            end else if (sel <= 8) begin
                period($urandom_range(1, 7), $urandom_range(1, 6), 1'b1);
            end else if (sel == 9) begin
                for (int i = 0, n = $urandom_range(1, 3); i < n; i++)
                    drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end else if (sel == 10) begin
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            end else begin
                period(1, 1, 1'b1);
            end
        end
        for (int p = 0; p < 4; p++) period(4, 3, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        chk("final_locked", 32'(o_locked), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule : tb_div_clk_monitor
`default_nettype wire
